// File: rtl/team_06_echo_sequencer.sv
// Echo sequencer: per-sample controller sitting in front of the SRAM read/write stage.
// On each ADC sample it issues one search (read of the delayed sample), mixes the echo
// into the dry sample, drives the DAC output, then issues one record (write) of either the
// mixed or the dry sample.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sampleTick        one-cycle strobe, audioIn valid
//   audioIn[7:0]      dry sample, offset-binary (0x80 = silence)
//   enable            echo on (0 = bypass, no search issued)
//   feedback          1 = record mixed sample, 0 = record dry sample
//   delay[12:0]       echo distance in samples
//   decayShift[2:0]   echo attenuation as arithmetic right shift
//   memBusy           SRAM busy
//   memAudio[7:0]     delayed sample returned by the read/write stage
//   search, record    one-cycle read / write commands
//   offset[12:0]      past-sample offset (-delay mod 8192)
//   effectAudioOut    sample to be stored
//   audioOut          processed sample to DAC
//   overrun           sticky, a pending sample was overwritten
//   memTimeout        sticky, a memory wait exceeded TIMEOUT cycles
module team_06_echo_sequencer #(
  parameter int unsigned WAIT_MIN = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sampleTick,
  input  logic [7:0]  audioIn,
  input  logic        enable,
  input  logic        feedback,
  input  logic [12:0] delay,
  input  logic [2:0]  decayShift,
  input  logic        memBusy,
  input  logic [7:0]  memAudio,
  output logic        search,
  output logic        record,
  output logic [12:0] offset,
  output logic [7:0]  effectAudioOut,
  output logic [7:0]  audioOut,
  output logic        overrun,
  output logic        memTimeout
);

  localparam logic [7:0] WaitMin = 8'(WAIT_MIN);
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StSearch, StWaitRd, StMix, StRecord, StWaitWr
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  dry_q, dry_d;
  logic        pending_q, pending_d;
  logic [7:0]  cur_dry_q, cur_dry_d;
  logic        en_q, en_d;
  logic [7:0]  echo_q, echo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [12:0] offset_q, offset_d;
  logic [7:0]  audio_q, audio_d;
  logic [7:0]  eff_q, eff_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;

  logic              idle_take;
  logic [7:0]        cnt_inc;
  logic              wait_done;
  logic              wait_expired;
  logic signed [8:0] echo_s;
  logic signed [8:0] echo_term;
  logic signed [9:0] sum_s;
  logic [7:0]        sum_sat;

  assign idle_take    = (state_q == StIdle) && pending_q;
  // Exit test uses the post-increment count so the minimum wait is exactly WAIT_MIN cycles.
  assign cnt_inc      = cnt_q + 8'd1;
  assign wait_done    = (cnt_inc >= WaitMin) && !memBusy;
  assign wait_expired = (cnt_inc >= TimeoutCnt);

  // Offset-binary echo to signed, attenuate, add to dry and clamp to 0..255.
  assign echo_s    = $signed({1'b0, echo_q}) - 9'sd128;
  assign echo_term = echo_s >>> decayShift;
  assign sum_s     = $signed({2'b00, cur_dry_q}) + $signed({echo_term[8], echo_term});
  assign sum_sat   = sum_s[9] ? 8'h00 : (sum_s[8] ? 8'hFF : sum_s[7:0]);

  always_comb begin
    state_d   = state_q;
    dry_d     = dry_q;
    pending_d = pending_q;
    cur_dry_d = cur_dry_q;
    en_d      = en_q;
    echo_d    = echo_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    audio_d   = audio_q;
    eff_d     = eff_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    search    = 1'b0;
    record    = 1'b0;

    if (idle_take) begin
      pending_d = 1'b0;
    end
    // A tick coinciding with the IDLE hand-off refills pending without counting as overrun.
    if (sampleTick) begin
      dry_d     = audioIn;
      pending_d = 1'b1;
      if (pending_q && !idle_take) begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          cur_dry_d = dry_q;
          en_d      = enable;
          offset_d  = 13'd0 - delay;
          state_d   = enable ? StSearch : StMix;
        end
      end
      StSearch: begin
        search  = 1'b1;
        cnt_d   = 8'd0;
        state_d = StWaitRd;
      end
      StWaitRd: begin
        cnt_d = cnt_inc;
        if (wait_done) begin
          echo_d  = memAudio;
          state_d = StMix;
        end else if (wait_expired) begin
          echo_d    = 8'h80;
          timeout_d = 1'b1;
          state_d   = StMix;
        end
      end
      StMix: begin
        if (en_q) begin
          audio_d = sum_sat;
          eff_d   = feedback ? sum_sat : cur_dry_q;
        end else begin
          audio_d = cur_dry_q;
          eff_d   = cur_dry_q;
        end
        state_d = StRecord;
      end
      StRecord: begin
        record  = 1'b1;
        cnt_d   = 8'd0;
        state_d = StWaitWr;
      end
      StWaitWr: begin
        cnt_d = cnt_inc;
        if (wait_done) begin
          state_d = StIdle;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dry_q     <= 8'h80;
      pending_q <= 1'b0;
      cur_dry_q <= 8'h80;
      en_q      <= 1'b0;
      echo_q    <= 8'h80;
      cnt_q     <= 8'd0;
      offset_q  <= 13'd0;
      audio_q   <= 8'h80;
      eff_q     <= 8'h80;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dry_q     <= dry_d;
      pending_q <= pending_d;
      cur_dry_q <= cur_dry_d;
      en_q      <= en_d;
      echo_q    <= echo_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      audio_q   <= audio_d;
      eff_q     <= eff_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign offset         = offset_q;
  assign audioOut       = audio_q;
  assign effectAudioOut = eff_q;
  assign overrun        = overrun_q;
  assign memTimeout     = timeout_q;

endmodule

// File: doc/team_06_echo_sequencer.md
Name: team_06_echo_sequencer

Overview:
- Per-sample controller directly upstream of the SRAM read/write stage.
- On each incoming audio sample it issues a `search` with the computed delay offset and waits for the delayed sample.
- It mixes the delayed sample with the dry input, drives the DAC-side output, then issues a `record` of the mixed (feedback) or dry sample.
- It enforces strict one-search-then-one-record ordering per sample and reports overruns and memory timeouts.

Parameters:
- WAIT_MIN, 3: minimum cycles after a search/record pulse before `memBusy` is sampled as "done".
- TIMEOUT, 255: maximum cycles spent in a wait state before abandoning; 8-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sampleTick  in  1  one-cycle strobe; a new ADC sample is valid on audioIn
- audioIn  in  8  dry sample, unsigned offset-binary (128 = silence)
- enable  in  1  echo on; when 0 the block runs in bypass
- feedback  in  1  1 = record the mixed sample, 0 = record the dry sample
- delay  in  13  echo distance in samples (0..8191)
- decayShift  in  3  echo attenuation, right shift 0..7
- memBusy  in  1  SRAM busy, the same net the read/write stage sees
- memAudio  in  8  delayed sample from the read/write stage's audio output
- search  out  1  one-cycle read command
- record  out  1  one-cycle write command
- offset  out  13  past-sample offset to the read/write stage
- effectAudioOut  out  8  sample to be stored
- audioOut  out  8  processed sample to DAC
- overrun  out  1  sticky; a tick was dropped
- memTimeout  out  1  sticky; a wait exceeded TIMEOUT

Behaviour:
- Reset (synchronous, on the clk edge with rst=1):
  - state=IDLE; search=0, record=0; offset=0.
  - effectAudioOut=0x80, audioOut=0x80.
  - overrun=0, memTimeout=0; pending=0; counters=0.
- Sample capture:
  - A sampleTick latches audioIn into dryReg and sets pending, regardless of state.
  - If pending is already set when a new tick arrives: dryReg is overwritten and overrun is set (sticky until rst).
- offset = (13'd0 - delay) mod 8192, registered. delay=0 gives 0; delay=1 gives 0x1FFF.
- States:
  - IDLE: if pending, clear pending and copy dryReg to curDry. Go to SEARCH if enable=1, otherwise go to MIX with echoTerm=0.
  - SEARCH: search=1 for exactly this cycle. Go to WAIT_RD and clear the wait counter.
  - WAIT_RD: increment the counter each cycle.
    - Once counter >= WAIT_MIN and memBusy=0, capture memAudio into echoReg and go to MIX.
    - If counter reaches TIMEOUT first, set memTimeout, use echoReg=0x80, and go to MIX.
  - MIX (1 cycle):
    - e = signed(echoReg) - 128, a 9-bit signed value.
    - echoTerm = e >>> decayShift (arithmetic shift).
    - sum = curDry + echoTerm, computed 10-bit signed, saturated to 0..255.
    - audioOut <= sum (bypass: audioOut <= curDry).
    - effectAudioOut <= (enable & feedback) ? sum : curDry.
    - Go to RECORD.
  - RECORD: record=1 for exactly this cycle. Go to WAIT_WR and clear the counter.
  - WAIT_WR: same exit rule as WAIT_RD. Timeout sets memTimeout. Go to IDLE.
- Ordering and outputs:
  - search and record are never high in the same cycle.
  - Each is high for at most one cycle per sample.
  - Exactly one record is issued per processed sample, including in bypass.
- Latency: tick to audioOut update = 1 (IDLE) + 1 + WAIT_RD + 1 cycles. The minimum is 6 with WAIT_MIN=3 and memBusy low.
- enable, delay, feedback and decayShift are sampled at IDLE exit and at MIX respectively. Changes mid-sample affect the next sample only.
- A tick arriving in the same cycle as the IDLE exit is latched as the next pending sample; it does not count as an overrun.
- rst asserted mid-sequence aborts immediately to IDLE. No further search/record pulse is emitted.

Test Plan:
- Reset, then idle 10 cycles -> audioOut=0x80, effectAudioOut=0x80, search=record=0, flags=0.
- enable=0, tick audioIn=0x50, memBusy=0 -> no search; one record pulse; audioOut=0x50, effectAudioOut=0x50.
- enable=1, feedback=1, delay=1, decayShift=1, audioIn=0x80, memAudio=0xC0 -> offset=0x1FFF; search then record; audioOut=0xA0, effectAudioOut=0xA0.
- Saturation: audioIn=0xF0, memAudio=0xFF, decayShift=0 -> audioOut=0xFF. Then audioIn=0x10, memAudio=0x00 -> audioOut=0x00.
- memBusy held high for 300 cycles after search -> memTimeout=1 after 255 wait cycles; echo treated as 0x80; audioOut=dry; record still issued.
- Three ticks 2 cycles apart during one sequence -> overrun=1; the last audioIn value is the next sample processed; exactly two record pulses total.
